// File: rtl/vga_pixel_fetch_if.sv
// Beam-counter/sync inputs, frame-store write port and pixel outputs of the pixel fetch stage.
interface vga_pixel_fetch_if;
  logic [9:0]  CounterX;
  logic [8:0]  CounterY;
  logic        inDisplayArea;
  logic        vga_h_sync_in;
  logic        vga_v_sync_in;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        vga_h_sync;
  logic        vga_v_sync;
  logic        vga_blank_n;
  logic        frame_start;
  logic [7:0]  frame_count;

  modport master (
    output CounterX, CounterY, inDisplayArea, vga_h_sync_in, vga_v_sync_in,
           wr_en, wr_addr, wr_data,
    input  vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync, vga_blank_n,
           frame_start, frame_count
  );

  modport slave (
    input  CounterX, CounterY, inDisplayArea, vga_h_sync_in, vga_v_sync_in,
           wr_en, wr_addr, wr_data,
    output vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync, vga_blank_n,
           frame_start, frame_count
  );
endinterface

// File: rtl/vga_pixel_fetch.sv
// Three-stage pixel pipe: counters -> frame-store address -> RAM byte -> RGB/syncs, all outputs
// aligned to the same beam position. Writes into the 64x64 store are always accepted.
module vga_pixel_fetch #(
  parameter int          SCALE_LOG2   = 0,
  parameter int          X_OFF        = 0,
  parameter int          Y_OFF        = 0,
  parameter logic [23:0] BORDER_COLOR = 24'h000040
) (
  input  logic              clk,
  input  logic              reset,
  vga_pixel_fetch_if.slave  bus
);
  localparam int          SPAN = 64 << SCALE_LOG2;
  localparam logic [10:0] X_LO = 11'(X_OFF);
  localparam logic [10:0] X_HI = 11'(X_OFF + SPAN);
  localparam logic [10:0] Y_LO = 11'(Y_OFF);
  localparam logic [10:0] Y_HI = 11'(Y_OFF + SPAN);

  logic [7:0]  mem [4096];
  logic [7:0]  rd_data_q;

  logic [11:0] rd_addr_d, rd_addr_q;
  logic        img1_d, img1_q;
  logic        frame_start_d, frame_start_q;
  logic [7:0]  frame_count_d, frame_count_q;
  logic        img2_d, img2_q;
  logic        disp2_d, disp2_q;
  logic        hs2_d, hs2_q;
  logic        vs2_d, vs2_q;
  logic [23:0] rgb_d, rgb_q;
  logic        blank_n_d, blank_n_q;
  logic        hs_d, hs_q;
  logic        vs_d, vs_q;
  logic [9:0]  dx, dy;
  logic [10:0] cx, cy;

  // Registered read after write in the same process gives old data on a same-address collision.
  always_ff @(posedge clk) begin
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
    rd_data_q <= mem[rd_addr_q];
  end

  always_comb begin
    cx            = {1'b0, bus.CounterX};
    cy            = {2'b0, bus.CounterY};
    dx            = bus.CounterX - 10'(X_OFF);
    dy            = {1'b0, bus.CounterY} - 10'(Y_OFF);
    img1_d        = (cx >= X_LO) && (cx < X_HI) && (cy >= Y_LO) && (cy < Y_HI);
    rd_addr_d     = {6'(dy >> SCALE_LOG2), 6'(dx >> SCALE_LOG2)};
    frame_start_d = (bus.CounterX == 10'd0) && (bus.CounterY == 9'd0);
    frame_count_d = frame_count_q + {7'd0, frame_start_d};

    // Sync/display inputs already lag the counters by one cycle, so one register lines them up.
    img2_d  = img1_q;
    disp2_d = bus.inDisplayArea;
    hs2_d   = bus.vga_h_sync_in;
    vs2_d   = bus.vga_v_sync_in;

    rgb_d = 24'h000000;
    if (disp2_q) rgb_d = img2_q ? {3{rd_data_q}} : BORDER_COLOR;
    blank_n_d = disp2_q;
    hs_d      = hs2_q;
    vs_d      = vs2_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr_q     <= 12'd0;
      img1_q        <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 8'd0;
      img2_q        <= 1'b0;
      disp2_q       <= 1'b0;
      hs2_q         <= 1'b1;
      vs2_q         <= 1'b1;
      rgb_q         <= 24'h000000;
      blank_n_q     <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
    end else begin
      rd_addr_q     <= rd_addr_d;
      img1_q        <= img1_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
      img2_q        <= img2_d;
      disp2_q       <= disp2_d;
      hs2_q         <= hs2_d;
      vs2_q         <= vs2_d;
      rgb_q         <= rgb_d;
      blank_n_q     <= blank_n_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
    end
  end

  assign bus.vga_r       = rgb_q[23:16];
  assign bus.vga_g       = rgb_q[15:8];
  assign bus.vga_b       = rgb_q[7:0];
  assign bus.vga_blank_n = blank_n_q;
  assign bus.vga_h_sync  = hs_q;
  assign bus.vga_v_sync  = vs_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_count = frame_count_q;
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench: three DUTs (unscaled, 2x scaled, offset image) share one stimulus stream.
module tb_vga_pixel_fetch;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic p_disp, p_hs, p_vs;

  vga_pixel_fetch_if i0 ();
  vga_pixel_fetch_if i1 ();
  vga_pixel_fetch_if i2 ();

  vga_pixel_fetch #(.SCALE_LOG2(0)) dut0 (.clk(clk), .reset(reset), .bus(i0));
  vga_pixel_fetch #(.SCALE_LOG2(1)) dut1 (.clk(clk), .reset(reset), .bus(i1));
  vga_pixel_fetch #(.SCALE_LOG2(0), .X_OFF(100), .Y_OFF(50)) dut2 (.clk(clk), .reset(reset), .bus(i2));

  always #5 clk = ~clk;

  function automatic logic [23:0] rgb_of0();
    return {i0.vga_r, i0.vga_g, i0.vga_b};
  endfunction
  function automatic logic [23:0] rgb_of1();
    return {i1.vga_r, i1.vga_g, i1.vga_b};
  endfunction
  function automatic logic [23:0] rgb_of2();
    return {i2.vga_r, i2.vga_g, i2.vga_b};
  endfunction

  task automatic set_wr(input logic en, input logic [11:0] a, input logic [7:0] d);
    i0.wr_en = en; i0.wr_addr = a; i0.wr_data = d;
    i1.wr_en = en; i1.wr_addr = a; i1.wr_data = d;
    i2.wr_en = en; i2.wr_addr = a; i2.wr_data = d;
  endtask

  // Present one pixel's counters; its display/sync flags follow one cycle later, like the sync generator.
  task automatic drive(input logic [9:0] x, input logic [8:0] y, input logic disp, input logic hs, input logic vs);
    i0.CounterX = x; i0.CounterY = y; i0.inDisplayArea = p_disp; i0.vga_h_sync_in = p_hs; i0.vga_v_sync_in = p_vs;
    i1.CounterX = x; i1.CounterY = y; i1.inDisplayArea = p_disp; i1.vga_h_sync_in = p_hs; i1.vga_v_sync_in = p_vs;
    i2.CounterX = x; i2.CounterY = y; i2.inDisplayArea = p_disp; i2.vga_h_sync_in = p_hs; i2.vga_v_sync_in = p_vs;
    p_disp = disp; p_hs = hs; p_vs = vs;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(10'd300, 9'd5, 1'b0, 1'b1, 1'b1);
    drive(10'd300, 9'd5, 1'b0, 1'b1, 1'b1);
    drive(10'd300, 9'd5, 1'b0, 1'b1, 1'b1);
    checks++;
    if (rgb_of0() !== 24'h0 || i0.vga_blank_n !== 1'b0) begin
      errors++; $display("FAIL reset_rgb: got %h blank_n %b, expected 000000 blank_n 0", rgb_of0(), i0.vga_blank_n);
    end
    checks++;
    if (i0.vga_h_sync !== 1'b1 || i0.vga_v_sync !== 1'b1) begin
      errors++; $display("FAIL reset_sync: got h %b v %b, expected 1 1", i0.vga_h_sync, i0.vga_v_sync);
    end
    checks++;
    if (i0.frame_start !== 1'b0 || i0.frame_count !== 8'd0) begin
      errors++; $display("FAIL reset_frame: got fs %b cnt %0d, expected 0 0", i0.frame_start, i0.frame_count);
    end
    reset = 1'b0;
    set_wr(1'b1, 12'h000, 8'h11);
    drive(10'd300, 9'd5, 1'b0, 1'b1, 1'b1);
    set_wr(1'b1, 12'h041, 8'hA5);
    drive(10'd300, 9'd5, 1'b0, 1'b1, 1'b1);
    set_wr(1'b0, 12'h000, 8'h00);
    drive(10'd300, 9'd5, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_fetch();
    drive(10'd1, 9'd1, 1'b1, 1'b1, 1'b1);
    drive(10'd300, 9'd1, 1'b0, 1'b1, 1'b1);
    drive(10'd300, 9'd1, 1'b0, 1'b1, 1'b1);
    checks++;
    if (rgb_of0() !== 24'hA5A5A5 || i0.vga_blank_n !== 1'b1) begin
      errors++; $display("FAIL fetch_scale0: got %h blank_n %b, expected a5a5a5 blank_n 1", rgb_of0(), i0.vga_blank_n);
    end
    checks++;
    if (rgb_of1() !== 24'h111111) begin
      errors++; $display("FAIL fetch_scale1_addr0: got %h, expected 111111", rgb_of1());
    end
    checks++;
    if (rgb_of2() !== 24'h000040) begin
      errors++; $display("FAIL fetch_offset_border: got %h, expected 000040", rgb_of2());
    end
  endtask

  task automatic test_offset();
    drive(10'd99, 9'd50, 1'b1, 1'b1, 1'b1);
    drive(10'd100, 9'd50, 1'b1, 1'b1, 1'b1);
    drive(10'd101, 9'd50, 1'b0, 1'b1, 1'b1);
    checks++;
    if (rgb_of2() !== 24'h000040) begin
      errors++; $display("FAIL offset_left_edge: got %h, expected 000040", rgb_of2());
    end
    drive(10'd102, 9'd50, 1'b0, 1'b1, 1'b1);
    checks++;
    if (rgb_of2() !== 24'h111111) begin
      errors++; $display("FAIL offset_first_pixel: got %h, expected 111111", rgb_of2());
    end
    drive(10'd103, 9'd50, 1'b0, 1'b1, 1'b1);
    checks++;
    if (rgb_of2() !== 24'h000000 || i2.vga_blank_n !== 1'b0) begin
      errors++; $display("FAIL offset_blanked: got %h blank_n %b, expected 000000 blank_n 0", rgb_of2(), i2.vga_blank_n);
    end
  endtask

  task automatic test_scale();
    logic [9:0]  xs [7] = '{10'd2, 10'd3, 10'd2, 10'd3, 10'd128, 10'd300, 10'd300};
    logic [8:0]  ys [7] = '{9'd2, 9'd2, 9'd3, 9'd3, 9'd2, 9'd2, 9'd2};
    logic [23:0] ex [5] = '{24'h3C3C3C, 24'h3C3C3C, 24'h3C3C3C, 24'h3C3C3C, 24'h000040};
    set_wr(1'b1, 12'h041, 8'h3C);
    drive(10'd300, 9'd2, 1'b0, 1'b1, 1'b1);
    set_wr(1'b0, 12'h000, 8'h00);
    for (int n = 0; n < 7; n++) begin
      drive(xs[n], ys[n], (n < 5), 1'b1, 1'b1);
      if (n >= 2) begin
        checks++;
        if (rgb_of1() !== ex[n-2]) begin
          errors++; $display("FAIL scale_pixel_%0d: got %h, expected %h", n - 2, rgb_of1(), ex[n-2]);
        end
      end
    end
  endtask

  task automatic test_sync();
    int lows = 0;
    logic exp_h;
    for (int x = 650; x <= 760; x++) begin
      drive(10'(x), 9'd10, 1'b0, !(x >= 656 && x <= 750), 1'b1);
      if (x >= 652) begin
        exp_h = !((x - 2) >= 656 && (x - 2) <= 750);
        checks++;
        if (i0.vga_h_sync !== exp_h || i0.vga_v_sync !== 1'b1) begin
          errors++; $display("FAIL sync_x%0d: got h %b v %b, expected h %b v 1", x - 2, i0.vga_h_sync, i0.vga_v_sync, exp_h);
        end
        if (i0.vga_h_sync === 1'b0) lows++;
      end
    end
    checks++;
    if (lows != 95) begin
      errors++; $display("FAIL sync_low_width: got %0d cycles, expected 95", lows);
    end
  endtask

  task automatic test_collision();
    drive(10'd0, 9'd0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (i0.frame_start !== 1'b1 || i0.frame_count !== 8'd1) begin
      errors++; $display("FAIL coll_fs1: got fs %b cnt %0d, expected 1 1", i0.frame_start, i0.frame_count);
    end
    set_wr(1'b1, 12'h000, 8'hFF);
    drive(10'd1, 9'd0, 1'b0, 1'b1, 1'b1);
    set_wr(1'b0, 12'h000, 8'h00);
    checks++;
    if (i0.frame_start !== 1'b0) begin
      errors++; $display("FAIL coll_fs_pulse: got %b, expected 0", i0.frame_start);
    end
    drive(10'd300, 9'd0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (rgb_of0() !== 24'h111111) begin
      errors++; $display("FAIL coll_old_data: got %h, expected 111111", rgb_of0());
    end
    drive(10'd300, 9'd0, 1'b0, 1'b1, 1'b1);
    drive(10'd0, 9'd0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (i0.frame_count !== 8'd2) begin
      errors++; $display("FAIL coll_fc2: got %0d, expected 2", i0.frame_count);
    end
    drive(10'd1, 9'd0, 1'b0, 1'b1, 1'b1);
    drive(10'd300, 9'd0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (rgb_of0() !== 24'hFFFFFF) begin
      errors++; $display("FAIL coll_new_data: got %h, expected ffffff", rgb_of0());
    end
  endtask

  task automatic test_reset_midline();
    drive(10'd299, 9'd10, 1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    drive(10'd300, 9'd10, 1'b0, 1'b0, 1'b0);
    drive(10'd300, 9'd10, 1'b0, 1'b0, 1'b0);
    checks++;
    if (rgb_of0() !== 24'h0 || i0.vga_blank_n !== 1'b0 || i0.vga_h_sync !== 1'b1 || i0.vga_v_sync !== 1'b1) begin
      errors++; $display("FAIL midreset_out: got %h blank_n %b h %b v %b, expected 000000 0 1 1",
                         rgb_of0(), i0.vga_blank_n, i0.vga_h_sync, i0.vga_v_sync);
    end
    checks++;
    if (i0.frame_count !== 8'd0 || i0.frame_start !== 1'b0) begin
      errors++; $display("FAIL midreset_frame: got cnt %0d fs %b, expected 0 0", i0.frame_count, i0.frame_start);
    end
    reset = 1'b0;
    drive(10'd1, 9'd1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (i0.vga_blank_n !== 1'b0 || i0.vga_h_sync !== 1'b1) begin
      errors++; $display("FAIL midreset_r1: got blank_n %b h %b, expected 0 1", i0.vga_blank_n, i0.vga_h_sync);
    end
    drive(10'd5, 9'd5, 1'b0, 1'b1, 1'b1);
    checks++;
    if (rgb_of0() !== 24'h0 || i0.vga_blank_n !== 1'b0) begin
      errors++; $display("FAIL midreset_r2: got %h blank_n %b, expected 000000 0", rgb_of0(), i0.vga_blank_n);
    end
    drive(10'd5, 9'd5, 1'b0, 1'b1, 1'b1);
    checks++;
    if (rgb_of0() !== 24'h3C3C3C || i0.vga_blank_n !== 1'b1) begin
      errors++; $display("FAIL midreset_first_pixel: got %h blank_n %b, expected 3c3c3c 1", rgb_of0(), i0.vga_blank_n);
    end
  endtask

  task automatic test_frame_wrap();
    for (int f = 0; f < 256; f++) begin
      drive(10'd0, 9'd0, 1'b0, 1'b1, 1'b1);
      checks++;
      if (i0.frame_start !== 1'b1 || i0.frame_count !== 8'((f + 1) % 256)) begin
        errors++; $display("FAIL wrap_frame_%0d: got fs %b cnt %0d, expected 1 %0d", f, i0.frame_start, i0.frame_count, (f + 1) % 256);
      end
      drive(10'd1, 9'd0, 1'b0, 1'b1, 1'b1);
      checks++;
      if (i0.frame_start !== 1'b0) begin
        errors++; $display("FAIL wrap_pulse_%0d: got fs %b, expected 0", f, i0.frame_start);
      end
    end
    checks++;
    if (i0.frame_count !== 8'd0) begin
      errors++; $display("FAIL wrap_final: got %0d, expected 0", i0.frame_count);
    end
  endtask

  initial begin
    reset = 1'b1;
    p_disp = 1'b0; p_hs = 1'b1; p_vs = 1'b1;
    set_wr(1'b0, 12'h000, 8'h00);
    test_reset();
    test_fetch();
    test_offset();
    test_scale();
    test_sync();
    test_collision();
    test_reset_midline();
    test_frame_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
